psw_flag_unit: RTL

- Consumer end of the PSW J/K flag interface. Holds the NZVC program-status flags in four JK flip-flops, driven by the per-flag J/K inputs from the ALU flag logic.
- Evaluates the 16 branch conditions from the held flags.
- Provides a PSW save/restore stack (interrupt entry and return) with overflow and underflow detection.
- Sits between the ALU flag logic and the control sequencer/branch unit.

---
 rtl/psw_flag_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/psw_flag_unit.sv
// psw_flag_unit: NZVC flags held in JK flip-flops, 16-way branch condition
// evaluation, and a LIFO save/restore stack with sticky over/underflow error.
`default_nettype none

module psw_flag_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_en,
  input  logic             J_N,
  input  logic             K_N,
  input  logic             J_Z,
  input  logic             K_Z,
  input  logic             J_V,
  input  logic             K_V,
  input  logic             J_C,
  input  logic             K_C,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       cond,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C,
  output logic [3:0]       psw_out,
  output logic             branch_taken,
  output logic [PTR_W:0]   stack_depth,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam logic [PTR_W:0]   c_one      = 1;
  localparam logic [PTR_W-1:0] c_one_idx  = 1;
  localparam logic [PTR_W:0]   c_depth    = DEPTH[PTR_W:0];

  logic [3:0]       r_flags;
  logic [PTR_W:0]   r_depth;
  logic             r_err;
  logic [3:0]       r_stack [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_push_do;
  logic             w_pop_do;
  logic             w_err_evt;
  logic [PTR_W-1:0] w_push_idx;
  logic [PTR_W-1:0] w_pop_idx;
  logic [3:0]       w_j;
  logic [3:0]       w_k;
  logic [3:0]       w_jk_next;
  logic [3:0]       w_flags_next;
  logic             w_nv;
  logic             w_taken;

  assign w_full     = (r_depth == c_depth);
  assign w_empty    = (r_depth == '0);
  assign w_push_do  = push & ~pop & ~w_full;
  assign w_pop_do   = pop & ~push & ~w_empty;
  assign w_err_evt  = (push & pop) | (push & ~pop & w_full) | (pop & ~push & w_empty);

  // When not full the low bits of depth address the next free slot; when
  // depth == DEPTH the low bits wrap to 0, so minus one still yields the top.
  assign w_push_idx = r_depth[PTR_W-1:0];
  assign w_pop_idx  = r_depth[PTR_W-1:0] - c_one_idx;

  assign w_j = {J_N, J_Z, J_V, J_C};
  assign w_k = {K_N, K_Z, K_V, K_C};

  // Per-bit JK characteristic: Q+ = J&~Q | ~K&Q
  assign w_jk_next = (w_j & ~r_flags) | (~w_k & r_flags);

  always_comb begin
    w_flags_next = r_flags;
    if (w_pop_do) begin
      w_flags_next = r_stack[w_pop_idx];
    end else if (flag_en) begin
      w_flags_next = w_jk_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      r_flags <= w_flags_next;
      if (w_push_do) begin
        r_depth <= r_depth + c_one;
      end else if (w_pop_do) begin
        r_depth <= r_depth - c_one;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  // Stack storage carries no reset: entries are only read below depth.
  always_ff @(posedge clk) begin
    if (w_push_do) begin
      r_stack[w_push_idx] <= r_flags;
    end
  end

  assign w_nv = r_flags[3] ^ r_flags[1];

  always_comb begin
    w_taken = 1'b0;
    case (cond)
      4'd0:    w_taken = 1'b1;
      4'd1:    w_taken = ~r_flags[2];
      4'd2:    w_taken = r_flags[2];
      4'd3:    w_taken = ~w_nv;
      4'd4:    w_taken = w_nv;
      4'd5:    w_taken = ~(r_flags[2] | w_nv);
      4'd6:    w_taken = r_flags[2] | w_nv;
      4'd7:    w_taken = ~r_flags[3];
      4'd8:    w_taken = r_flags[3];
      4'd9:    w_taken = ~(r_flags[0] | r_flags[2]);
      4'd10:   w_taken = r_flags[0] | r_flags[2];
      4'd11:   w_taken = ~r_flags[1];
      4'd12:   w_taken = r_flags[1];
      4'd13:   w_taken = ~r_flags[0];
      4'd14:   w_taken = r_flags[0];
      default: w_taken = 1'b0;
    endcase
  end

  assign N            = r_flags[3];
  assign Z            = r_flags[2];
  assign V            = r_flags[1];
  assign C            = r_flags[0];
  assign psw_out      = r_flags;
  assign branch_taken = w_taken;
  assign stack_depth  = r_depth;
  assign stack_empty  = w_empty;
  assign stack_full   = w_full;
  assign stack_err    = r_err;

endmodule

`default_nettype wire
